// File: rtl/param_sync_fifo_if.sv
// Handshake bundle for param_sync_fifo: write/read requests, read data and status.
// The master side drives requests; the FIFO sits on the slave side.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags and a standard or first-word-fall-through read port.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  param_sync_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] cnt_t;
  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_LVL);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_LVL);
  localparam cnt_t ONE_C    = cnt_t'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers keep one extra wrap bit so full and empty never alias.
  cnt_t wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic wr_acc, rd_acc;

  always_comb begin
    wr_acc = bus.wr_en && !full_q;
    rd_acc = bus.rd_en && !empty_q;
    wptr_d = wr_acc ? wptr_q + ONE_C : wptr_q;
    rptr_d = rd_acc ? rptr_q + ONE_C : rptr_q;
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    // A fresh error wins over a clear requested in the same cycle.
    ovf_d = (bus.wr_en && full_q)  || (ovf_q && !bus.clr_err);
    udf_d = (bus.rd_en && empty_q) || (udf_q && !bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            rd_data_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
          end
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is presented directly; forced to zero while nothing is stored.
      assign bus.rd_data  = empty_q ? '0 : mem[rptr_q[ADDR_WIDTH-1:0]];
      assign bus.rd_valid = !empty_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
